// File: rtl/bounce_scanner.sv
// bounce_scanner: one-hot scan register that bounces between the end bits or
// rotates in either direction, stepping once every dwell+1 enabled cycles.
// It raises end-of-travel pulses and counts arrivals at bit 0 in a
// wrapping counter that has a sticky overflow flag.
module bounce_scanner #(
    parameter int N             = 8,
    parameter int COUNTER_WIDTH = 8,
    parameter int DWELL_WIDTH   = 4,
    localparam int PW           = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rsta,
    input  logic                     ena,
    input  logic [1:0]               mode,
    input  logic [DWELL_WIDTH-1:0]   dwell,
    input  logic                     load,
    input  logic [PW-1:0]            load_pos,
    input  logic                     clr_count,
    output logic [N-1:0]             Q,
    output logic [PW-1:0]            pos,
    output logic                     dir,
    output logic                     tc_lsb,
    output logic                     tc_msb,
    output logic [COUNTER_WIDTH-1:0] period_count,
    output logic                     count_ovf
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_R  = 2'b01,
        MODE_ROT_L  = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    localparam logic [PW-1:0] POS_MAX = PW'(N - 1);

    mode_t                    mode_sel;
    logic                     active;
    logic                     step;
    logic                     eff_dir;
    logic [PW-1:0]            step_pos;
    logic                     step_dir;
    logic [PW-1:0]            load_clamped;

    logic [PW-1:0]            pos_reg, pos_next;
    logic                     dir_reg, dir_next;
    logic [DWELL_WIDTH-1:0]   presc_reg, presc_next;
    logic [N-1:0]             q_reg, q_next;
    logic                     tc_lsb_reg, tc_lsb_next;
    logic                     tc_msb_reg, tc_msb_next;
    logic [COUNTER_WIDTH-1:0] count_reg;
    logic                     ovf_reg;

    assign mode_sel = mode_t'(mode);
    assign active   = ena && (mode_sel != MODE_HOLD);
    // ">=" rather than "==" so that lowering dwell below the running
    // prescaler value fires the step on the next enabled cycle.
    assign step     = active && (presc_reg >= dwell);

    // Out-of-range load positions land on the MSB.
    assign load_clamped = ({1'b0, load_pos} > {1'b0, POS_MAX}) ? POS_MAX : load_pos;

    // Position and direction a step would produce in the current mode.
    always_comb begin
        step_pos = pos_reg;
        step_dir = dir_reg;
        eff_dir  = dir_reg;
        case (mode_sel)
            MODE_BOUNCE: begin
                if (pos_reg == '0) begin
                    eff_dir = 1'b0;
                end else if (pos_reg == POS_MAX) begin
                    eff_dir = 1'b1;
                end
                step_pos = eff_dir ? (pos_reg - 1'b1) : (pos_reg + 1'b1);
                if (step_pos == POS_MAX) begin
                    step_dir = 1'b1;
                end else if (step_pos == '0) begin
                    step_dir = 1'b0;
                end else begin
                    step_dir = eff_dir;
                end
            end
            MODE_ROT_R: begin
                step_pos = (pos_reg == '0) ? POS_MAX : (pos_reg - 1'b1);
                step_dir = 1'b1;
            end
            MODE_ROT_L: begin
                step_pos = (pos_reg == POS_MAX) ? '0 : (pos_reg + 1'b1);
                step_dir = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Next scan state: a load overrides a coincident step and never pulses tc.
    always_comb begin
        pos_next    = pos_reg;
        dir_next    = dir_reg;
        presc_next  = presc_reg;
        tc_lsb_next = 1'b0;
        tc_msb_next = 1'b0;
        if (load) begin
            pos_next   = load_clamped;
            dir_next   = 1'b1;
            presc_next = '0;
        end else if (step) begin
            pos_next    = step_pos;
            dir_next    = step_dir;
            presc_next  = '0;
            tc_lsb_next = (step_pos == '0);
            tc_msb_next = (step_pos == POS_MAX);
        end else if (active) begin
            presc_next = presc_reg + 1'b1;
        end
    end

    // One-hot decode of the next position so Q is registered alongside pos.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign q_next[gi] = (pos_next == PW'(gi));
        end
    endgenerate

    // Scan state registers; reset parks the pattern on the MSB heading to LSB.
    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            pos_reg    <= POS_MAX;
            dir_reg    <= 1'b1;
            presc_reg  <= '0;
            q_reg      <= {1'b1, {(N-1){1'b0}}};
            tc_lsb_reg <= 1'b0;
            tc_msb_reg <= 1'b0;
        end else begin
            pos_reg    <= pos_next;
            dir_reg    <= dir_next;
            presc_reg  <= presc_next;
            q_reg      <= q_next;
            tc_lsb_reg <= tc_lsb_next;
            tc_msb_reg <= tc_msb_next;
        end
    end

    // Arrival-at-LSB counter with sticky wrap flag; clear beats increment.
    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (clr_count) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else if (tc_lsb_next) begin
            count_reg <= count_reg + 1'b1;
            if (&count_reg) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign Q            = q_reg;
    assign pos          = pos_reg;
    assign dir          = dir_reg;
    assign tc_lsb       = tc_lsb_reg;
    assign tc_msb       = tc_msb_reg;
    assign period_count = count_reg;
    assign count_ovf    = ovf_reg;

endmodule
